iobus_uart_tx: RTL and testbench
================================

Name: iobus_uart_tx

Overview:
- Memory-mapped UART transmitter on the OTTER IOBUS, covering the transmit direction opposite the programmer's serial receive path.
- The MCU writes bytes over IOBUS_ADDR/IOBUS_OUT/IOBUS_WR; the block queues them in a small FIFO and serializes each as an 8N1 frame on TX.
- Status is returned on RD_DATA, which the top level muxes into IOBUS_IN.

Parameters:
- CLK_HZ, 50000000, core clock frequency in Hz.
- BAUD, 115200, line rate; DIV = CLK_HZ/BAUD with integer truncation, must be >= 2 (default 434).
- BASE_ADDR, 32'h1100_0040, IOBUS base address; must be word aligned.
- FIFO_DEPTH, 8, byte entries; power of two, 2..64.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, asynchronous assert, active-low (0 = reset).
- IOBUS_ADDR  in  32  MCU IO address.
- IOBUS_OUT  in  32  MCU write data.
- IOBUS_WR  in  1  MCU write strobe, one cycle per write.
- RD_DATA  out  32  registered status read data; 0 when the address does not match.
- TX  out  1  serial output; idles high.
- IRQ  out  1  level-high when the FIFO is empty and the shifter is idle (TX drained).

Behaviour:
- Register map:
  - BASE+0 TXDATA (write): pushes IOBUS_OUT[7:0]; bits [31:8] are ignored.
  - BASE+4 STATUS (read): bit0 BUSY (shifter active), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky), bits[15:8] COUNT (FIFO occupancy); other bits 0.
  - BASE+4 (write): any write clears OVF.
- Reads: RD_DATA is registered. The value presented on cycle n+1 reflects IOBUS_ADDR and state at cycle n.
- Reset (RST=0): asynchronous. TX=1, RD_DATA=0, IRQ=1, FIFO emptied, OVF=0, FSM=IDLE, baud counter=0, bit counter=0. Reset mid-frame aborts the frame immediately; TX goes high without a glitch low.
- Push: write to TXDATA while not FULL stores the byte and increments COUNT at the edge.
- Write to TXDATA while FULL: byte dropped, OVF set. FULL is evaluated before any same-cycle pop, so the write is dropped even if a pop occurs that cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If FIFO not empty, pop the head into the shift register, load the baud counter with DIV-1, go to START. TX falls on the following cycle.
  - START: TX=0 for DIV cycles.
  - DATA: 8 bits, LSB first, each held DIV cycles; bit counter 0..7.
  - STOP: TX=1 for DIV cycles.
  - From STOP: if FIFO not empty, pop and go directly to START, with no extra idle cycle between frames. Otherwise go to IDLE.
- Frame timing: exactly 10*DIV cycles from the first START cycle to the end of STOP.
- BUSY=1 in START/DATA/STOP.
- Push and pop in the same cycle (FIFO not full) leave COUNT unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. COUNT is held in log2(FIFO_DEPTH)+1 bits and zero-extended into STATUS.
- Writes to addresses other than BASE+0 and BASE+4 are ignored.
- TX is driven directly from a flop; no combinational path to TX.

Decomposition:
- Package otter_uart_pkg holds:
  - typedef enum logic [1:0] uart_tx_state_t {IDLE, START, DATA, STOP};
  - localparams TXDATA_OFS=0 and STATUS_OFS=4;
  - STATUS bit-index constants.
- Sub-module sync_fifo, parameterized on WIDTH and DEPTH:
  - ports CLK, RST (active-low async), push, pop, din, dout, full, empty, count;
  - dout is the head entry, valid whenever not empty.
- The top level holds the address decode, OVF and RD_DATA registers, the baud/bit counters and the FSM.

Test Plan:
- Single byte (CLK_HZ=16, BAUD=1, so DIV=16): write 0xA5 to BASE+0 -> TX low for 16 cycles, then 1,0,1,0,0,1,0,1 (16 cycles each), then high for 16. BUSY=1 for 160 cycles, then IRQ=1.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles -> two frames with zero gap; the second START begins the cycle after the first STOP ends; COUNT reads 1 during frame 1.
- Overflow (DEPTH=8): write 10 bytes rapidly -> the first pops immediately, 8 are stored, the 10th is dropped. STATUS reads FULL=1, OVF=1, COUNT=8. A write to BASE+4 clears OVF; exactly 9 frames are emitted.
- Status read: IOBUS_ADDR=BASE+4 with the FIFO empty and idle -> RD_DATA=0x0000_0004 one cycle later. IOBUS_ADDR=BASE+8 -> RD_DATA=0.
- Reset mid-frame: assert RST=0 during DATA bit 3 -> TX=1 asynchronously; after release STATUS=0x4, IRQ=1, and no residual frame is emitted.
- Wrap-around: 20 sequential writes, each issued whenever FULL=0 -> 20 frames in order, with payload matching bytes 0x01..0x14.

Source files
------------

// File: rtl/otter_uart_pkg.sv
// Shared types and constants for the OTTER IOBUS UART transmitter.
package otter_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    // Register offsets from the block's base address
    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    // STATUS register bit positions
    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_EMPTY     = 2;
    localparam int unsigned ST_OVF       = 3;
    localparam int unsigned ST_COUNT_LSB = 8;
    localparam int unsigned ST_COUNT_W   = 8;

endpackage

// File: rtl/iobus_uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through output and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates validity
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS.
// TXDATA at BASE+0 queues bytes; STATUS at BASE+4 reports shifter/FIFO state.
module iobus_uart_tx
    import otter_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0040,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        TX,
    output logic        IRQ
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned BW  = $clog2(DIV);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIV - 1);

    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           tx_q, tx_d;
    logic           ovf_q;
    logic [31:0]    rd_q;
    logic [31:0]    status;

    logic           wr_txdata;
    logic           wr_status;
    logic           rd_status;
    logic           fifo_push;
    logic           fifo_pop;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           baud_zero;
    logic           unused_wdata_hi;

    assign unused_wdata_hi = ^IOBUS_OUT[31:8];

    assign wr_txdata = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR + TXDATA_OFS);
    assign wr_status = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR + STATUS_OFS);
    assign rd_status = (IOBUS_ADDR == BASE_ADDR + STATUS_OFS);

    // FULL is sampled before any same-cycle pop, so a write while full drops
    assign fifo_push = wr_txdata && !fifo_full;

    assign baud_zero = (baud_q == '0);

    assign TX      = tx_q;
    assign RD_DATA = rd_q;
    assign IRQ     = fifo_empty && (state_q == IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (IOBUS_OUT[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Assemble the STATUS word from current state
    always_comb begin
        status = '0;
        status[ST_BUSY]  = (state_q != IDLE);
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = ovf_q;
        status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
    end

    // Sticky overflow flag and registered read-back
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
            rd_q  <= '0;
        end else begin
            if (wr_txdata && fifo_full) ovf_q <= 1'b1;
            else if (wr_status)         ovf_q <= 1'b0;
            rd_q <= rd_status ? status : '0;
        end
    end

    // Transmit FSM state, counters and the TX output flop
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; tx_d is the line level for the next cycle so TX stays a pure flop
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    baud_d   = BAUD_RELOAD;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end

            START: begin
                if (baud_zero) begin
                    state_d = DATA;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end

            DATA: begin
                if (baud_zero) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Shift right so the next bit to send is always shreg_q[1]
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end

            STOP: begin
                if (baud_zero) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_dout;
                        baud_d   = BAUD_RELOAD;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Self-checking bench for iobus_uart_tx with DIV=16 and an 8-entry FIFO.
// Bytes are queued on the scoreboard when written and popped by a TX frame monitor.
module tb_iobus_uart_tx;

    localparam logic [31:0] BASE = 32'h1100_0040;
    localparam int          DIV  = 16;

    logic        CLK;
    logic        RST;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] RD_DATA;
    logic        TX;
    logic        IRQ;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int frames_rx = 0;
    int last_start = 0;
    int prev_start = 0;

    logic [7:0] sb[$];
    logic [7:0] mon_rx;
    logic [7:0] mon_exp;
    bit         mon_ab;

    iobus_uart_tx #(
        .CLK_HZ     (16),
        .BAUD       (1),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .RD_DATA    (RD_DATA),
        .TX         (TX),
        .IRQ        (IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // ---------------- frame monitor ----------------
    task automatic mon_wait(input int n, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n && !ab; i++) begin
            @(negedge CLK);
            if (RST !== 1'b1) ab = 1'b1;
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (RST === 1'b1 && TX === 1'b0) begin
                prev_start = last_start;
                last_start = cyc;
                mon_wait(8, mon_ab);
                if (mon_ab) continue;
                for (int b = 0; b < 8; b++) begin
                    mon_wait(DIV, mon_ab);
                    if (mon_ab) break;
                    mon_rx[b] = TX;
                end
                if (mon_ab) continue;
                mon_wait(DIV, mon_ab);
                if (mon_ab) continue;
                checks++;
                if (TX !== 1'b1) begin
                    failures++;
                    $display("FAIL stop_bit: got %b expected 1", TX);
                end
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL frame_unexpected: got %h expected no frame", mon_rx);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_rx !== mon_exp) begin
                        failures++;
                        $display("FAIL frame_payload: got %h expected %h", mon_rx, mon_exp);
                    end
                end
                frames_rx++;
            end
        end
    end

    // ---------------- drive helpers ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (frames_rx >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_irq(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (IRQ === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        IOBUS_ADDR = '0;
        IOBUS_OUT  = '0;
        IOBUS_WR   = 1'b0;
        RST = 1'b1;
        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (TX !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", TX); end
        checks++;
        if (IRQ !== 1'b1) begin failures++; $display("FAIL reset_irq: got %b expected 1", IRQ); end
        checks++;
        if (RD_DATA !== 32'h0) begin failures++; $display("FAIL reset_rd: got %h expected 0", RD_DATA); end
        #2 RST = 1'b1;
        @(negedge CLK);
        IOBUS_ADDR = BASE + 32'd4;
        @(negedge CLK);
        checks++;
        if (RD_DATA !== 32'h4) begin failures++; $display("FAIL reset_status: got %h expected 00000004", RD_DATA); end
    endtask

    task automatic test_status_read;
        IOBUS_ADDR = BASE + 32'd4;
        @(negedge CLK);
        checks++;
        if (RD_DATA !== 32'h4) begin failures++; $display("FAIL status_idle: got %h expected 00000004", RD_DATA); end
        IOBUS_ADDR = BASE + 32'd8;
        @(negedge CLK);
        checks++;
        if (RD_DATA !== 32'h0) begin failures++; $display("FAIL status_unmapped: got %h expected 0", RD_DATA); end
        bus_write(BASE + 32'd8, 32'h55);
        IOBUS_ADDR = BASE + 32'd4;
        @(negedge CLK);
        checks++;
        if (RD_DATA !== 32'h4) begin failures++; $display("FAIL unmapped_write: got %h expected 00000004", RD_DATA); end
        checks++;
        if (TX !== 1'b1) begin failures++; $display("FAIL unmapped_tx: got %b expected 1", TX); end
    endtask

    task automatic test_single_byte;
        logic [7:0]  pat;
        logic        exp_tx;
        logic [31:0] exp_rd;
        pat = 8'hA5;
        IOBUS_ADDR = BASE;
        IOBUS_OUT  = {24'hDEAD_BE, pat};
        IOBUS_WR   = 1'b1;
        sb.push_back(pat);
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = BASE + 32'd4;
        checks++;
        if (TX !== 1'b1) begin failures++; $display("FAIL single_pre_tx: got %b expected 1", TX); end
        for (int i = 0; i < 10 * DIV; i++) begin
            @(negedge CLK);
            if (i < DIV)            exp_tx = 1'b0;
            else if (i < 9 * DIV)   exp_tx = pat[(i - DIV) / DIV];
            else                    exp_tx = 1'b1;
            exp_rd = (i == 0) ? 32'h0000_0100 : 32'h0000_0005;
            checks++;
            if (TX !== exp_tx) begin failures++; $display("FAIL single_tx cyc %0d: got %b expected %b", i, TX, exp_tx); end
            checks++;
            if (RD_DATA !== exp_rd) begin failures++; $display("FAIL single_status cyc %0d: got %h expected %h", i, RD_DATA, exp_rd); end
            checks++;
            if (IRQ !== 1'b0) begin failures++; $display("FAIL single_irq cyc %0d: got %b expected 0", i, IRQ); end
        end
        @(negedge CLK);
        checks++;
        if (TX !== 1'b1) begin failures++; $display("FAIL single_post_tx: got %b expected 1", TX); end
        checks++;
        if (IRQ !== 1'b1) begin failures++; $display("FAIL single_post_irq: got %b expected 1", IRQ); end
        @(negedge CLK);
        checks++;
        if (RD_DATA !== 32'h4) begin failures++; $display("FAIL single_post_status: got %h expected 00000004", RD_DATA); end
    endtask

    task automatic test_back_to_back;
        int f0;
        bit ok;
        f0 = frames_rx;
        sb.push_back(8'h00);
        bus_write(BASE, 32'h0000_0000);
        sb.push_back(8'hFF);
        bus_write(BASE, 32'h0000_00FF);
        IOBUS_ADDR = BASE + 32'd4;
        repeat (50) @(negedge CLK);
        checks++;
        if (RD_DATA !== 32'h0000_0101) begin failures++; $display("FAIL b2b_count: got %h expected 00000101", RD_DATA); end
        wait_frames(f0 + 2, 2 * 10 * DIV + 50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_frames: got %0d expected %0d", frames_rx - f0, 2); end
        checks++;
        if (last_start - prev_start !== 10 * DIV) begin
            failures++;
            $display("FAIL b2b_gap: got %0d expected %0d", last_start - prev_start, 10 * DIV);
        end
        wait_irq(50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_irq: got %b expected 1", IRQ); end
    endtask

    task automatic test_overflow;
        int f0;
        bit ok;
        f0 = frames_rx;
        for (int k = 0; k < 10; k++) begin
            IOBUS_ADDR = BASE;
            IOBUS_OUT  = 32'h30 + 32'(k);
            IOBUS_WR   = 1'b1;
            if (k < 9) sb.push_back(8'h30 + 8'(k));
            @(negedge CLK);
        end
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = BASE + 32'd4;
        @(negedge CLK);
        checks++;
        if (RD_DATA !== 32'h0000_080B) begin failures++; $display("FAIL ovf_status: got %h expected 0000080b", RD_DATA); end
        bus_write(BASE + 32'd4, 32'h0);
        @(negedge CLK);
        checks++;
        if (RD_DATA !== 32'h0000_0803) begin failures++; $display("FAIL ovf_clear: got %h expected 00000803", RD_DATA); end
        wait_frames(f0 + 9, 9 * 10 * DIV + 100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ovf_frames: got %0d expected 9", frames_rx - f0); end
        wait_irq(100, ok);
        repeat (2) @(negedge CLK);
        checks++;
        if (frames_rx - f0 !== 9) begin failures++; $display("FAIL ovf_frame_total: got %0d expected 9", frames_rx - f0); end
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL ovf_scoreboard: got %0d pending expected 0", sb.size()); end
        checks++;
        if (RD_DATA !== 32'h4) begin failures++; $display("FAIL ovf_final_status: got %h expected 00000004", RD_DATA); end
    endtask

    task automatic test_reset_mid_frame;
        int f0;
        int lows;
        f0 = frames_rx;
        sb.push_back(8'h52);
        bus_write(BASE, 32'h52);
        IOBUS_ADDR = BASE + 32'd4;
        repeat (72) @(negedge CLK);
        checks++;
        if (TX !== 1'b0) begin failures++; $display("FAIL rst_mid_pre_tx: got %b expected 0", TX); end
        #2 RST = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (TX !== 1'b1) begin failures++; $display("FAIL rst_mid_tx: got %b expected 1", TX); end
        checks++;
        if (IRQ !== 1'b1) begin failures++; $display("FAIL rst_mid_irq: got %b expected 1", IRQ); end
        checks++;
        if (RD_DATA !== 32'h0) begin failures++; $display("FAIL rst_mid_rd: got %h expected 0", RD_DATA); end
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (RD_DATA !== 32'h4) begin failures++; $display("FAIL rst_mid_status: got %h expected 00000004", RD_DATA); end
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin failures++; $display("FAIL rst_mid_residual: got %0d low cycles expected 0", lows); end
        checks++;
        if (frames_rx !== f0) begin failures++; $display("FAIL rst_mid_frames: got %0d expected %0d", frames_rx, f0); end
    endtask

    task automatic test_wrap;
        int f0;
        int sent;
        int guard;
        bit ok;
        f0 = frames_rx;
        sent = 0;
        guard = 0;
        IOBUS_ADDR = BASE + 32'd4;
        @(negedge CLK);
        while (sent < 20 && guard < 6000) begin
            @(negedge CLK);
            guard++;
            if (RD_DATA[1] === 1'b0) begin
                sb.push_back(8'(sent + 1));
                bus_write(BASE, 32'(sent + 1));
                sent++;
                IOBUS_ADDR = BASE + 32'd4;
            end
        end
        checks++;
        if (sent !== 20) begin failures++; $display("FAIL wrap_sent: got %0d expected 20", sent); end
        wait_frames(f0 + 20, 25 * 10 * DIV, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wrap_frames: got %0d expected 20", frames_rx - f0); end
        wait_irq(100, ok);
        repeat (2) @(negedge CLK);
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL wrap_scoreboard: got %0d pending expected 0", sb.size()); end
        checks++;
        if (RD_DATA !== 32'h4) begin failures++; $display("FAIL wrap_final_status: got %h expected 00000004", RD_DATA); end
    endtask

    initial begin : watchdog
        #(10 * 60000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_status_read();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
